// File: rtl/spike_rate_monitor.sv
// Windowed spike counter with min-ISI tracking; one result per closed window, out_valid 1 cycle after close.
// Results queue in a small FIFO drained by out_valid/out_ready; a close into a full, non-popping FIFO is dropped.

module srm_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         empty, full, push, pop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_vld = !empty;
  assign pop    = rd_vld && rd_rdy;
  // A pop in the same cycle frees the head slot, so a full FIFO can still take a write.
  assign wr_rdy = !full || pop;
  assign push   = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

module spike_rate_monitor #(
  parameter int WIN_W = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_count,
  output logic [7:0]       out_isi_min,
  output logic             out_ovf,
  output logic             dropped
);
  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [7:0] count;
    logic [7:0] isi_min;
    logic       ovf;
  } result_t;

  state_t state, state_nxt;

  logic             fresh;
  logic [WIN_W-1:0] cyc, len;
  logic [7:0]       cnt, gap, min_acc;
  logic             ovf_acc, have;

  logic             start, close;
  logic [WIN_W-1:0] cur_len, cur_cyc;
  logic [7:0]       base_cnt, base_gap, base_min;
  logic             base_ovf, base_have;
  logic [7:0]       new_cnt, new_gap, new_min;
  logic             new_ovf, new_have;

  result_t push_dat, head;
  logic    push_vld, push_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The IDLE entry cycle and the cycle after a close are both window cycle 0: accumulators
  // are taken as cleared and win_len is sampled combinationally so cycle 0 can also close.
  always_comb begin
    start     = (state == IDLE) || fresh;
    cur_len   = start ? ((win_len == '0) ? WIN_W'(1) : win_len) : len;
    cur_cyc   = start ? '0 : cyc;
    base_cnt  = start ? 8'd0 : cnt;
    base_ovf  = start ? 1'b0 : ovf_acc;
    base_have = start ? 1'b0 : have;
    base_gap  = start ? 8'd0 : gap;
    base_min  = start ? 8'hFF : min_acc;

    new_cnt  = base_cnt;
    new_ovf  = base_ovf;
    new_min  = base_min;
    new_have = base_have | spike_in;
    new_gap  = (base_gap == 8'hFF) ? 8'hFF : base_gap + 8'd1;
    if (spike_in) begin
      new_gap = 8'd1;
      if (base_cnt == 8'hFF) new_ovf = 1'b1;
      else                   new_cnt = base_cnt + 8'd1;
      if (base_have && (base_gap < base_min)) new_min = base_gap;
    end

    close    = enable && (cur_cyc == cur_len - WIN_W'(1));
    push_vld = close;
    push_dat = '{count: new_cnt, isi_min: new_min, ovf: new_ovf};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fresh   <= 1'b0;
      cyc     <= '0;
      len     <= '0;
      cnt     <= 8'd0;
      ovf_acc <= 1'b0;
      have    <= 1'b0;
      gap     <= 8'd0;
      min_acc <= 8'hFF;
    end else if (enable) begin
      if (close) begin
        fresh <= 1'b1;
        cyc   <= '0;
      end else begin
        fresh   <= 1'b0;
        cyc     <= cur_cyc + WIN_W'(1);
        len     <= cur_len;
        cnt     <= new_cnt;
        ovf_acc <= new_ovf;
        have    <= new_have;
        gap     <= new_gap;
        min_acc <= new_min;
      end
    end else begin
      fresh <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       dropped <= 1'b0;
    else if (push_vld && !push_rdy) dropped <= 1'b1;
  end

  srm_fifo #(
    .W     ($bits(result_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .wr_rdy (push_rdy),
    .rd_vld (out_valid),
    .rd_dat (head),
    .rd_rdy (out_ready)
  );

  // Idle value shown while empty doubles as the reset value of the result outputs.
  assign out_count   = out_valid ? head.count   : 8'd0;
  assign out_isi_min = out_valid ? head.isi_min : 8'hFF;
  assign out_ovf     = out_valid ? head.ovf     : 1'b0;
endmodule
